// File: rtl/bist_misr_analyzer.sv
// BIST response analyzer: folds NUM_PATTERNS CUT responses into a MISR signature,
// compares the result against GOLDEN and aborts a run that stalls for TIMEOUT idle cycles.
module bist_misr_analyzer #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] POLY         = 8'hB8,
    parameter logic [WIDTH-1:0] SEED         = 8'h00,
    parameter int               NUM_PATTERNS = 16,
    parameter logic [WIDTH-1:0] GOLDEN       = 8'h00,
    parameter int               TIMEOUT      = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout_err,
    output logic [WIDTH-1:0] signature,
    output logic             bistSignal,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int BW = $clog2(NUM_PATTERNS + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(NUM_PATTERNS - 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sig;
    logic [BW-1:0]    r_beat_cnt;
    logic [IW-1:0]    r_idle_cnt;
    logic             r_done;
    logic             r_pass;
    logic             r_timeout;
    logic             r_bist;

    logic             w_accept;
    logic             w_last_beat;
    logic             w_idle_expire;
    logic [IW-1:0]    w_idle_inc;
    logic [WIDTH-1:0] w_misr_next;
    logic             w_sig_match;
    logic             w_load;
    logic             w_fire_timeout;
    logic             w_fire_check;

    // Handshake: a response beat transfers on any cycle where resp_valid and
    // resp_ready are both high; resp_ready is high exactly while in RUN.
    assign w_accept      = (r_state == ST_RUN) && resp_valid;
    assign w_last_beat   = w_accept && (r_beat_cnt == LAST_BEAT);
    assign w_idle_inc    = (r_idle_cnt == IDLE_LIMIT) ? r_idle_cnt : r_idle_cnt + IW'(1);
    // A beat arriving on the expiring cycle wins, so expiry requires no valid beat.
    assign w_idle_expire = (r_state == ST_RUN) && !resp_valid && (w_idle_inc == IDLE_LIMIT);
    assign w_misr_next   = {r_sig[WIDTH-2:0], 1'b0}
                         ^ (r_sig[WIDTH-1] ? POLY : '0)
                         ^ resp_data;
    assign w_sig_match   = (r_sig == GOLDEN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_load         = 1'b0;
        w_fire_timeout = 1'b0;
        w_fire_check   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_load       = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_last_beat) begin
                    w_state_next = ST_CHECK;
                end else if (w_idle_expire) begin
                    w_state_next   = ST_DONE;
                    w_fire_timeout = 1'b1;
                end
            end
            ST_CHECK: begin
                w_state_next = ST_DONE;
                w_fire_check = 1'b1;
            end
            ST_DONE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_load       = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sig      <= SEED;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_bist     <= 1'b0;
        end else begin
            if (w_load) begin
                r_sig      <= SEED;
                r_beat_cnt <= '0;
                r_idle_cnt <= '0;
                r_done     <= 1'b0;
                r_pass     <= 1'b0;
                r_timeout  <= 1'b0;
                r_bist     <= 1'b0;
            end else if (w_accept) begin
                r_sig      <= w_misr_next;
                r_beat_cnt <= r_beat_cnt + BW'(1);
                r_idle_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_idle_cnt <= w_idle_inc;
            end

            if (w_fire_timeout) begin
                r_done    <= 1'b1;
                r_pass    <= 1'b0;
                r_timeout <= 1'b1;
                r_bist    <= 1'b0;
            end else if (w_fire_check) begin
                r_done <= 1'b1;
                r_pass <= w_sig_match;
                r_bist <= w_sig_match;
            end
        end
    end

    assign resp_ready  = (r_state == ST_RUN);
    assign busy        = (r_state == ST_RUN) || (r_state == ST_CHECK);
    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout_err = r_timeout;
    assign signature   = r_sig;
    assign bistSignal  = r_bist;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Bench for bist_misr_analyzer: a short-run instance (2 patterns, timeout 4) and a
// long-run instance (16 patterns, timeout 6), checked against a MISR reference model.
module tb_bist_misr_analyzer;

    localparam int         W      = 8;
    localparam logic [7:0] POLY   = 8'hB8;
    localparam logic [7:0] SEED   = 8'h00;
    localparam logic [7:0] GOLDEN = 8'h00;

    logic         clk = 1'b0;
    logic         reset;
    logic         start       [2];
    logic         resp_valid  [2];
    logic [W-1:0] resp_data   [2];
    logic         resp_ready  [2];
    logic         busy        [2];
    logic         done        [2];
    logic         pass        [2];
    logic         timeout_err [2];
    logic [W-1:0] signature   [2];
    logic         bist        [2];
    logic [1:0]   dbg_state   [2];

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    bist_misr_analyzer #(.WIDTH(8), .POLY(POLY), .SEED(SEED), .NUM_PATTERNS(2),
                         .GOLDEN(GOLDEN), .TIMEOUT(4)) u_dut_a (
        .clk(clk), .reset(reset), .start(start[0]), .resp_valid(resp_valid[0]),
        .resp_data(resp_data[0]), .resp_ready(resp_ready[0]), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .timeout_err(timeout_err[0]),
        .signature(signature[0]), .bistSignal(bist[0]), .dbg_state(dbg_state[0])
    );

    bist_misr_analyzer #(.WIDTH(8), .POLY(POLY), .SEED(SEED), .NUM_PATTERNS(16),
                         .GOLDEN(GOLDEN), .TIMEOUT(6)) u_dut_b (
        .clk(clk), .reset(reset), .start(start[1]), .resp_valid(resp_valid[1]),
        .resp_data(resp_data[1]), .resp_ready(resp_ready[1]), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .timeout_err(timeout_err[1]),
        .signature(signature[1]), .bistSignal(bist[1]), .dbg_state(dbg_state[1])
    );

    typedef struct {
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] s0;
        logic [7:0] s1;
        logic       p;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference MISR step: double the signature modulo 2^8, fold in the taps when the
    // dropped bit was set, then add the response (all additions are carry-less).
    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] d);
        int doubled;
        doubled = (int'(s) * 2) % 256;
        return 8'(doubled) ^ ((int'(s) >= 128) ? POLY : 8'h00) ^ d;
    endfunction

    task automatic start_run(input int i);
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
        check("start_busy", busy[i], 1);
        check("start_ready", resp_ready[i], 1);
        check("start_done_clr", done[i], 0);
        check("start_pass_clr", pass[i], 0);
        check("start_tmo_clr", timeout_err[i], 0);
        check("start_bist_clr", bist[i], 0);
        check("start_sig_seed", signature[i], SEED);
    endtask

    task automatic beat(input int i, input logic [7:0] d);
        resp_valid[i] = 1'b1;
        resp_data[i]  = d;
        tick();
        resp_valid[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{d0: 8'h01, d1: 8'h02, s0: 8'h01, s1: 8'h00, p: 1'b1};
        vecs[1] = '{d0: 8'h80, d1: 8'h00, s0: 8'h80, s1: 8'hB8, p: 1'b0};
        vecs[2] = '{d0: 8'h40, d1: 8'h80, s0: 8'h40, s1: 8'h00, p: 1'b1};
        vecs[3] = '{d0: 8'hFF, d1: 8'hFE, s0: 8'hFF, s1: 8'hB8, p: 1'b0};
        vecs[4] = '{d0: 8'hC3, d1: 8'h00, s0: 8'hC3, s1: 8'h3E, p: 1'b0};
        vecs[5] = '{d0: 8'hA5, d1: 8'h5A, s0: 8'hA5, s1: 8'hA8, p: 1'b0};

        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i]      = 1'b0;
            resp_valid[i] = 1'b0;
            resp_data[i]  = '0;
        end
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            check("rst_busy", busy[i], 0);
            check("rst_ready", resp_ready[i], 0);
            check("rst_done", done[i], 0);
            check("rst_pass", pass[i], 0);
            check("rst_tmo", timeout_err[i], 0);
            check("rst_bist", bist[i], 0);
            check("rst_sig", signature[i], SEED);
        end
        reset = 1'b1;
        tick();

        // Two-pattern table: each run starts from the previous DONE
        for (int k = 0; k < 6; k++) begin
            start_run(0);
            beat(0, vecs[k].d0);
            check("vec_s0", signature[0], vecs[k].s0);
            check("vec_mid_done", done[0], 0);
            beat(0, vecs[k].d1);
            check("vec_s1", signature[0], vecs[k].s1);
            check("vec_check_busy", busy[0], 1);
            check("vec_check_ready", resp_ready[0], 0);
            check("vec_check_done", done[0], 0);
            tick();
            check("vec_done", done[0], 1);
            check("vec_pass", pass[0], vecs[k].p);
            check("vec_bist", bist[0], vecs[k].p);
            check("vec_tmo", timeout_err[0], 0);
            check("vec_busy_off", busy[0], 0);
            check("vec_sig_hold", signature[0], vecs[k].s1);
        end

        // Timeout with no beats at all
        start_run(0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("tmo_wait_done", done[0], 0);
            check("tmo_wait_ready", resp_ready[0], 1);
        end
        tick();
        check("tmo_done", done[0], 1);
        check("tmo_flag", timeout_err[0], 1);
        check("tmo_pass", pass[0], 0);
        check("tmo_bist", bist[0], 0);
        check("tmo_ready", resp_ready[0], 0);
        check("tmo_busy", busy[0], 0);

        // Timeout after one beat keeps the partial signature
        start_run(0);
        beat(0, 8'h55);
        check("ptmo_sig", signature[0], 8'h55);
        repeat (3) tick();
        check("ptmo_wait_done", done[0], 0);
        tick();
        check("ptmo_done", done[0], 1);
        check("ptmo_flag", timeout_err[0], 1);
        check("ptmo_sig_hold", signature[0], 8'h55);

        // start during RUN and CHECK is ignored
        start_run(0);
        beat(0, 8'h80);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("rs_run_sig", signature[0], 8'h80);
        check("rs_run_busy", busy[0], 1);
        check("rs_run_ready", resp_ready[0], 1);
        beat(0, 8'h00);
        check("rs_sig2", signature[0], 8'hB8);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("rs_check_done", done[0], 1);
        check("rs_check_busy", busy[0], 0);
        check("rs_check_sig", signature[0], 8'hB8);
        start_run(0);
        check("rs_rerun_state_busy", busy[0], 1);

        // Long instance: a beat on the would-expire cycle wins; last word drives sig to GOLDEN
        begin
            logic [7:0] words[16];
            logic [7:0] s;
            s = SEED;
            for (int k = 0; k < 15; k++) begin
                words[k] = 8'($urandom);
                s = misr_step(s, words[k]);
                exp_q.push_back(s);
            end
            words[15] = misr_step(s, 8'h00) ^ GOLDEN;
            exp_q.push_back(GOLDEN);
            start_run(1);
            beat(1, words[0]);
            check("bnd_sig0", signature[1], exp_q.pop_front());
            for (int g = 1; g < 3; g++) begin
                repeat (5) begin
                    resp_data[1] = 8'($urandom);
                    tick();
                end
                check("bnd_gap_done", done[1], 0);
                beat(1, words[g]);
                check("bnd_edge_sig", signature[1], exp_q.pop_front());
                check("bnd_edge_busy", busy[1], 1);
                check("bnd_edge_tmo", timeout_err[1], 0);
            end
            for (int k = 3; k < 16; k++) begin
                beat(1, words[k]);
                check("bnd_sig", signature[1], exp_q.pop_front());
            end
            tick();
            check("bnd_done", done[1], 1);
            check("bnd_pass", pass[1], 1);
            check("bnd_bist", bist[1], 1);
            check("bnd_tmo", timeout_err[1], 0);
        end

        // Random runs: gapped beats versus back-to-back beats of the same words
        for (int r = 0; r < 6; r++) begin
            logic [7:0] words[16];
            logic [7:0] s;
            int         gap;
            s = SEED;
            for (int k = 0; k < 16; k++) begin
                words[k] = 8'($urandom);
                s = misr_step(s, words[k]);
                exp_q.push_back(s);
            end
            start_run(1);
            for (int k = 0; k < 16; k++) begin
                gap = $urandom_range(0, 3);
                repeat (gap) begin
                    resp_data[1] = 8'($urandom);
                    tick();
                end
                beat(1, words[k]);
                check("rnd_sig", signature[1], exp_q.pop_front());
            end
            resp_valid[1] = 1'b1;
            resp_data[1]  = 8'($urandom);
            tick();
            resp_valid[1] = 1'b0;
            check("rnd_done", done[1], 1);
            check("rnd_extra_ignored", signature[1], s);
            check("rnd_pass", pass[1], (s == GOLDEN) ? 1'b1 : 1'b0);
            check("rnd_tmo", timeout_err[1], 0);
            start_run(1);
            for (int k = 0; k < 16; k++) begin
                beat(1, words[k]);
            end
            tick();
            check("b2b_done", done[1], 1);
            check("b2b_sig", signature[1], s);
        end

        // Asynchronous reset in the middle of a run
        start_run(1);
        beat(1, 8'h3C);
        beat(1, 8'hC3);
        beat(1, 8'h99);
        check("mid_sig_nonseed", (signature[1] != SEED) ? 1'b1 : 1'b0, 1);
        reset = 1'b0;
        #2;
        check("mrst_busy", busy[1], 0);
        check("mrst_done", done[1], 0);
        check("mrst_bist", bist[1], 0);
        check("mrst_ready", resp_ready[1], 0);
        check("mrst_sig", signature[1], SEED);
        check("mrst_a_done", done[0], 0);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_busy", busy[1], 0);
        check("post_rst_sig", signature[1], SEED);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
